regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised integer register file with a per-register busy scoreboard and registered multi-port reads.
//  Sits between decode and execute in the RV32I core.
//  Execute writes results back through rd_*; decode reads operands through rs_* and marks destinations through issue_*.
//  Generalises the fixed 2-read, 32x32 file: configurable width, depth, read-port count, hazard reporting.
// PARAMETERS
//  XLEN      32                  data width of each register
//  NREG      32                  number of registers; x0 hardwired to zero
//  NRD       2                   number of read ports
//  AW        $clog2(NREG)        register address width (derived, do not override)
//  CW        $clog2(NREG+1)      busy counter width (derived, do not override)
// PORTS
//  req             in   1         clock, rising-edge
//  reset           in   1         asynchronous reset, active-low
//  stall_in        in   1         1 = hold all read outputs (writes/issues still proceed)
//  rs_read_in      in   1         1 = sample read ports this edge
//  rs_addr_in      in   NRD*AW    read addresses, port i at [i*AW +: AW]
//  rs_value_out    out  NRD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
//  rs_busy_out     out  NRD       registered busy flag of each sampled register
//  hazard_out      out  1         registered OR of rs_busy_out
//  issue_in        in   1         mark issue_rd_in busy (instruction with rd issued)
//  issue_rd_in     in   AW        destination being issued
//  rd_write_in     in   1         write-back strobe from execute
//  rd_in           in   AW        write-back destination
//  rd_value_in     in   XLEN      write-back data
//  busy_count_out  out  CW        registered number of busy registers
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - all registers 0; all busy bits 0.
//    - rs_value_out=0, rs_busy_out=0, hazard_out=0, busy_count_out=0.
//    - Reset mid-operation drops pending issues; no write survives.
//  - Write: posedge req with rd_write_in=1 and rd_in!=0: reg[rd_in] <= rd_value_in; busy[rd_in] <= 0.
//  - Issue: posedge req with issue_in=1 and issue_rd_in!=0: busy[issue_rd_in] <= 1.
//  - Simultaneous issue and write-back to the same register:
//    - data is written.
//    - busy ends at 1; the new producer wins.
//  - Write-back to a non-busy register: data written; busy stays 0 (no error).
//  - x0: writes and issues ignored; reads return 0 with busy 0 always.
//  - Read, latency 1 cycle: posedge req with rs_read_in=1 and stall_in=0, for each port i:
//    - rs_value_out[i] <= reg[addr_i]
//    - rs_busy_out[i] <= busy[addr_i]
//    - hazard_out <= |next rs_busy_out
//  - rs_read_in=0 or stall_in=1: rs_value_out, rs_busy_out, hazard_out hold their values.
//  - Same address on several ports: each port returns identical data; no port priority.
//  - Read values sample pre-edge state unless bypass is enabled (see CONFIGURATION).
//  - busy_count_out: registered population count of the post-edge busy vector; range 0..NREG-1.
//  - Addresses >= NREG (non-power-of-2 NREG): reads return 0/not busy; writes and issues ignored.
// CONFIGURATION
//  - REGFILE_BYPASS_EN defined, on a read edge, for each port with rd_write_in=1, rd_in==addr_i, rd_in!=0:
//    - rs_value_out[i] <= rd_value_in.
//    - rs_busy_out[i] <= 1 only if the same edge also issues to that register, else 0.
//    - Effective write-to-read latency is 0 cycles.
//  - REGFILE_BYPASS_EN undefined:
//    - reads see pre-edge contents and busy.
//    - A write is visible on the next read edge (write-to-read latency 1 cycle).
// TESTING
//  1. Reset:
//     - hold reset=0 2 cycles, release, read x1/x2.
//     - -> rs_value_out=0, rs_busy_out=2'b00, busy_count_out=0.
//  2. Write x5=32'hDEAD_BEEF, next cycle read x5 on port0 and x0 on port1.
//     - -> port0=DEADBEEF, port1=0, hazard_out=0.
//  3. Issue x3, next cycle read x3.
//     - -> rs_busy_out[0]=1, hazard_out=1, busy_count_out=1.
//     - Then write x3=7 -> busy_count_out=0, re-read gives 7, not busy.
//  4. Same edge: write x4=32'h1234 and read x4.
//     - -> with REGFILE_BYPASS_EN: 32'h1234 and busy 0.
//     - -> without: old value 0.
//  5. Same edge: issue x6 and write x6=9.
//     - -> reg=9, busy[6]=1, busy_count_out=1.
//     - Write x0=5 / issue x0 -> x0 reads 0, count unchanged.
//  6. With stall_in=1, write x7=42 and change rs_addr_in.
//     - -> outputs hold prior values.
//     - Release stall -> x7 reads 42; assert reset mid-pending-issue -> busy_count_out=0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with busy scoreboard, registered multi-port reads and busy count.
// Define REGFILE_BYPASS_EN to forward a same-edge write-back (and its issue) to matching read ports.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG),
    parameter int CW   = $clog2(NREG + 1)
) (
    input  logic                req,
    input  logic                reset,
    input  logic                stall_in,
    input  logic                rs_read_in,
    input  logic [NRD*AW-1:0]   rs_addr_in,
    output logic [NRD*XLEN-1:0] rs_value_out,
    output logic [NRD-1:0]      rs_busy_out,
    output logic                hazard_out,
    input  logic                issue_in,
    input  logic [AW-1:0]       issue_rd_in,
    input  logic                rd_write_in,
    input  logic [AW-1:0]       rd_in,
    input  logic [XLEN-1:0]     rd_value_in,
    output logic [CW-1:0]       busy_count_out
);
    localparam int NSLOT = 1 << AW;

    // Slots >= NREG and x0 are never written, so they read back as 0 / not busy.
    logic [XLEN-1:0]     regs_q [NSLOT];
    logic [XLEN-1:0]     regs_d [NSLOT];
    logic [NSLOT-1:0]    busy_q, busy_d, wr_hit, iss_hit;
    logic [NRD*XLEN-1:0] rs_value_q, rs_value_d;
    logic [NRD-1:0]      rs_busy_q, rs_busy_d;
    logic                hazard_q, hazard_d;
    logic [CW-1:0]       busy_count_q, busy_count_d;
    logic [AW-1:0]       a;

    always_comb begin
        wr_hit = '0;
        iss_hit = '0;
        for (int k = 1; k < NREG; k++) begin
            wr_hit[k] = rd_write_in && rd_in == AW'(k);
            iss_hit[k] = issue_in && issue_rd_in == AW'(k);
        end
        busy_count_d = '0;
        for (int k = 0; k < NSLOT; k++) begin
            regs_d[k] = wr_hit[k] ? rd_value_in : regs_q[k];
            busy_d[k] = iss_hit[k] | (busy_q[k] & ~wr_hit[k]);
            busy_count_d = busy_count_d + CW'(busy_d[k]);
        end
        rs_value_d = rs_value_q;
        rs_busy_d = rs_busy_q;
        a = '0;
        for (int i = 0; i < NRD; i++) begin
            a = rs_addr_in[i*AW +: AW];
            if (rs_read_in && !stall_in) begin
`ifdef REGFILE_BYPASS_EN
                rs_value_d[i*XLEN +: XLEN] = wr_hit[a] ? rd_value_in : regs_q[a];
                rs_busy_d[i] = wr_hit[a] ? iss_hit[a] : busy_q[a];
`else
                rs_value_d[i*XLEN +: XLEN] = regs_q[a];
                rs_busy_d[i] = busy_q[a];
`endif
            end
        end
        hazard_d = |rs_busy_d;
    end

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            rs_value_q <= '0;
            rs_busy_q <= '0;
            hazard_q <= 1'b0;
            busy_count_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            rs_value_q <= rs_value_d;
            rs_busy_q <= rs_busy_d;
            hazard_q <= hazard_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign rs_value_out = rs_value_q;
    assign rs_busy_out = rs_busy_q;
    assign hazard_out = hazard_q;
    assign busy_count_out = busy_count_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors with hand-computed expectations for regfile_scoreboard.
module tb_regfile_scoreboard;
    logic        req = 1'b0;
    logic        reset, stall_in, rs_read_in, issue_in, rd_write_in;
    logic [9:0]  rs_addr_in;
    logic [63:0] rs_value_out;
    logic [1:0]  rs_busy_out;
    logic        hazard_out;
    logic [4:0]  issue_rd_in, rd_in;
    logic [31:0] rd_value_in;
    logic [5:0]  busy_count_out;
    int checks = 0;
    int errors = 0;
    logic [63:0] held_val;
    logic [1:0]  held_busy;
    logic        held_haz;

    regfile_scoreboard dut (
        .req(req), .reset(reset), .stall_in(stall_in), .rs_read_in(rs_read_in),
        .rs_addr_in(rs_addr_in), .rs_value_out(rs_value_out), .rs_busy_out(rs_busy_out),
        .hazard_out(hazard_out), .issue_in(issue_in), .issue_rd_in(issue_rd_in),
        .rd_write_in(rd_write_in), .rd_in(rd_in), .rd_value_in(rd_value_in),
        .busy_count_out(busy_count_out)
    );

    always #5 req = ~req;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall_in = 0; rs_read_in = 0; issue_in = 0; rd_write_in = 0;
    endtask

    task automatic cyc();
        @(posedge req);
        @(negedge req);
        idle();
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        rs_read_in = 1;
        rs_addr_in = {a1, a0};
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        rd_write_in = 1; rd_in = r; rd_value_in = v;
    endtask

    task automatic iss(input logic [4:0] r);
        issue_in = 1; issue_rd_in = r;
    endtask

    initial begin
        reset = 0; idle(); rs_addr_in = '0; issue_rd_in = '0; rd_in = '0; rd_value_in = '0;
        repeat (2) @(negedge req);
        chk("rst_val", rs_value_out, 64'h0);
        chk("rst_cnt", 64'(busy_count_out), 64'd0);
        reset = 1;
        rd2(1, 2); cyc();
        chk("t1_val", rs_value_out, 64'h0);
        chk("t1_busy", 64'(rs_busy_out), 64'd0);
        chk("t1_cnt", 64'(busy_count_out), 64'd0);
        wr(5, 32'hDEAD_BEEF); cyc();
        rd2(5, 0); cyc();
        chk("t2_val", rs_value_out, {32'h0, 32'hDEAD_BEEF});
        chk("t2_haz", 64'(hazard_out), 64'd0);
        iss(3); cyc();
        chk("t3_cnt_iss", 64'(busy_count_out), 64'd1);
        rd2(3, 0); cyc();
        chk("t3_busy", 64'(rs_busy_out), 64'b01);
        chk("t3_haz", 64'(hazard_out), 64'd1);
        wr(3, 32'd7); cyc();
        chk("t3_cnt_wb", 64'(busy_count_out), 64'd0);
        rd2(3, 0); cyc();
        chk("t3_val", rs_value_out, {32'h0, 32'd7});
        chk("t3_busy_clr", 64'(rs_busy_out), 64'b00);
        chk("t3_haz_clr", 64'(hazard_out), 64'd0);
        wr(4, 32'h1234); rd2(4, 4); cyc();
`ifdef REGFILE_BYPASS_EN
        chk("t4_same_edge", rs_value_out, {32'h1234, 32'h1234});
`else
        chk("t4_same_edge", rs_value_out, 64'h0);
`endif
        chk("t4_busy", 64'(rs_busy_out), 64'b00);
        rd2(4, 4); cyc();
        chk("t4_next", rs_value_out, {32'h1234, 32'h1234});
        iss(6); wr(6, 32'd9); cyc();
        chk("t5_cnt", 64'(busy_count_out), 64'd1);
        wr(0, 32'd5); iss(0); cyc();
        chk("t5_x0_cnt", 64'(busy_count_out), 64'd1);
        rd2(6, 0); cyc();
        chk("t5_val", rs_value_out, {32'h0, 32'd9});
        chk("t5_busy", 64'(rs_busy_out), 64'b01);
        chk("t5_haz", 64'(hazard_out), 64'd1);
        iss(8); wr(8, 32'd11); rd2(8, 0); cyc();
`ifdef REGFILE_BYPASS_EN
        held_val = {32'h0, 32'd11}; held_busy = 2'b01; held_haz = 1;
`else
        held_val = 64'h0; held_busy = 2'b00; held_haz = 0;
`endif
        chk("t5b_val", rs_value_out, held_val);
        chk("t5b_busy", 64'(rs_busy_out), 64'(held_busy));
        chk("t5b_cnt", 64'(busy_count_out), 64'd2);
        stall_in = 1; wr(7, 32'd42); rd2(7, 5); cyc();
        chk("t6_hold_val", rs_value_out, held_val);
        chk("t6_hold_busy", 64'(rs_busy_out), 64'(held_busy));
        chk("t6_hold_haz", 64'(hazard_out), 64'(held_haz));
        rd2(7, 5); cyc();
        chk("t6_val", rs_value_out, {32'hDEAD_BEEF, 32'd42});
        chk("t6_haz", 64'(hazard_out), 64'd0);
        iss(9); cyc();
        chk("t6_cnt", 64'(busy_count_out), 64'd3);
        reset = 0; #1;
        chk("t6_rst_cnt", 64'(busy_count_out), 64'd0);
        chk("t6_rst_val", rs_value_out, 64'h0);
        @(negedge req); reset = 1;
        rd2(7, 6); cyc();
        chk("t6_post_val", rs_value_out, 64'h0);
        chk("t6_post_busy", 64'(rs_busy_out), 64'b00);
        chk("t6_post_cnt", 64'(busy_count_out), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
